// File: rtl/wshb_arbiter_2m_if.sv
// Wishbone classic bus bundle shared by the arbiter's master-side and slave-side ports.
// The master modport drives the request fields; the slave modport returns read data and ack.
interface wshb_arbiter_2m_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_ms;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_sm;
    logic            ack;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel,
        input  dat_sm, ack
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel,
        output dat_sm, ack
    );
endinterface

// File: rtl/wshb_arbiter_2m.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant, held for a master's whole cyc.
// Define WSHB_ARB_FIXED_PRIO_EN to make master 1 win every tie instead of alternating.
module wshb_arbiter_2m #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wshb_arbiter_2m_if.slave       m0,
    wshb_arbiter_2m_if.slave       m1,
    wshb_arbiter_2m_if.master      s,
    output logic [1:0]             gnt
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    typedef struct packed {
        logic            cyc;
        logic            stb;
        logic            we;
        logic [AW-1:0]   adr;
        logic [DW-1:0]   dat;
        logic [DW/8-1:0] sel;
    } req_t;

    state_t state, state_nxt, tie_winner;
    req_t   m0_req, m1_req, s_req;

    assign m0_req = {m0.cyc, m0.stb, m0.we, m0.adr, m0.dat_ms, m0.sel};
    assign m1_req = {m1.cyc, m1.stb, m1.we, m1.adr, m1.dat_ms, m1.sel};

`ifdef WSHB_ARB_FIXED_PRIO_EN
    assign tie_winner = GNT1;
`else
    logic last, last_nxt;

    // Master 0 wins the first tie out of reset because last starts at 1.
    assign tie_winner = last ? GNT0 : GNT1;

    always_comb begin
        last_nxt = last;
        if (state_nxt == GNT0) last_nxt = 1'b0;
        if (state_nxt == GNT1) last_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last <= 1'b1;
        else        last <= last_nxt;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A dropped cyc releases on that same edge; only the peer can be requesting then.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0.cyc && m1.cyc) state_nxt = tie_winner;
                else if (m0.cyc)      state_nxt = GNT0;
                else if (m1.cyc)      state_nxt = GNT1;
            end
            GNT0:    if (!m0.cyc) state_nxt = m1.cyc ? GNT1 : IDLE;
            GNT1:    if (!m1.cyc) state_nxt = m0.cyc ? GNT0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        s_req     = '0;
        m0.ack    = 1'b0;
        m0.dat_sm = '0;
        m1.ack    = 1'b0;
        m1.dat_sm = '0;
        gnt       = 2'b00;
        case (state)
            GNT0: begin
                s_req     = m0_req;
                m0.ack    = s.ack;
                m0.dat_sm = s.dat_sm;
                gnt       = 2'b01;
            end
            GNT1: begin
                s_req     = m1_req;
                m1.ack    = s.ack;
                m1.dat_sm = s.dat_sm;
                gnt       = 2'b10;
            end
            default: ;
        endcase
    end

    // IDLE drives zeros, which also masks a stray stb raised with cyc low.
    assign s.cyc    = s_req.cyc;
    assign s.stb    = s_req.stb;
    assign s.we     = s_req.we;
    assign s.adr    = s_req.adr;
    assign s.dat_ms = s_req.dat;
    assign s.sel    = s_req.sel;

endmodule

// File: tb/tb_wshb_arbiter_2m.sv
// Randomised self-checking bench for wshb_arbiter_2m against an owner/last-served grant model.
module tb_wshb_arbiter_2m;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef WSHB_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] gnt;

    always #5 clk = ~clk;

    wshb_arbiter_2m_if #(.AW(AW), .DW(DW)) m0_if ();
    wshb_arbiter_2m_if #(.AW(AW), .DW(DW)) m1_if ();
    wshb_arbiter_2m_if #(.AW(AW), .DW(DW)) s_if ();

    wshb_arbiter_2m #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .gnt   (gnt)
    );

    typedef struct packed {
        logic [1:0]      gnt;
        logic            cyc;
        logic            stb;
        logic            we;
        logic [AW-1:0]   adr;
        logic [DW-1:0]   dat_ms;
        logic [DW/8-1:0] sel;
        logic            ack0;
        logic            ack1;
        logic [DW-1:0]   dat0;
        logic [DW-1:0]   dat1;
    } obs_t;

    typedef struct {
        bit         c0;
        bit         c1;
        logic [1:0] rr;
        logic [1:0] fp;
    } tie_t;

    tie_t tie_tbl [9] = '{
        '{1'b1, 1'b1, 2'b01, 2'b10},
        '{1'b0, 1'b1, 2'b10, 2'b10},
        '{1'b1, 1'b1, 2'b10, 2'b10},
        '{1'b1, 1'b1, 2'b10, 2'b10},
        '{1'b1, 1'b0, 2'b01, 2'b01},
        '{1'b0, 1'b0, 2'b00, 2'b00},
        '{1'b1, 1'b1, 2'b10, 2'b10},
        '{1'b0, 1'b0, 2'b00, 2'b00},
        '{1'b1, 1'b1, 2'b01, 2'b10}
    };

    int errors = 0;
    int checks = 0;
    int owner = -1;      // model: -1 nobody, else index of the master holding the bus
    int last_srv = 1;    // model: master most recently granted

    // Grant rules: an owner keeps the bus while its cyc is high; otherwise pick among requesters.
    function automatic void model_edge();
        bit c0 = m0_if.cyc;
        bit c1 = m1_if.cyc;
        if (owner == 0 && c0) return;
        if (owner == 1 && c1) return;
        if (c0 && c1)  owner = FIXED_PRIO ? 1 : 1 - last_srv;
        else if (c0)   owner = 0;
        else if (c1)   owner = 1;
        else           owner = -1;
        if (owner >= 0) last_srv = owner;
    endfunction

    function automatic obs_t expected();
        obs_t e = '0;
        if (owner == 0) begin
            e.gnt = 2'b01;
            e.cyc = m0_if.cyc; e.stb = m0_if.stb; e.we = m0_if.we;
            e.adr = m0_if.adr; e.dat_ms = m0_if.dat_ms; e.sel = m0_if.sel;
            e.ack0 = s_if.ack; e.dat0 = s_if.dat_sm;
        end else if (owner == 1) begin
            e.gnt = 2'b10;
            e.cyc = m1_if.cyc; e.stb = m1_if.stb; e.we = m1_if.we;
            e.adr = m1_if.adr; e.dat_ms = m1_if.dat_ms; e.sel = m1_if.sel;
            e.ack1 = s_if.ack; e.dat1 = s_if.dat_sm;
        end
        return e;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o.gnt = gnt;
        o.cyc = s_if.cyc; o.stb = s_if.stb; o.we = s_if.we;
        o.adr = s_if.adr; o.dat_ms = s_if.dat_ms; o.sel = s_if.sel;
        o.ack0 = m0_if.ack; o.ack1 = m1_if.ack;
        o.dat0 = m0_if.dat_sm; o.dat1 = m1_if.dat_sm;
        return o;
    endfunction

    task automatic idle_inputs();
        m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
        m0_if.adr = '0; m0_if.dat_ms = '0; m0_if.sel = '0;
        m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
        m1_if.adr = '0; m1_if.dat_ms = '0; m1_if.sel = '0;
        s_if.ack = 1'b0; s_if.dat_sm = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        owner = -1;
        last_srv = 1;
    endtask

    task automatic test_reset();
        obs_t o;
        idle_inputs();
        #1;
        rst_n = 1'b0;
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h1234_5678;
        s_if.ack = 1'b1; s_if.dat_sm = 32'hDEAD_BEEF;
        #1;
        o = observed();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", o);
        end
        @(posedge clk);
        #1;
        o = observed();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_held_edge: got %h expected 0", o);
        end
        idle_inputs();
        rst_n = 1'b1;
        owner = -1;
        last_srv = 1;
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle: gnt got %b expected 00", gnt);
        end
    endtask

    task automatic test_single_master();
        logic ack_v;
        do_reset();
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b1;
        m0_if.adr = 32'h0000_0C80; m0_if.dat_ms = 32'hA5A5_0001; m0_if.sel = 4'hF;
        s_if.ack = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b00 || s_if.cyc !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: gnt=%b s_cyc=%b expected 00/0 before edge", gnt, s_if.cyc);
        end
        for (int i = 0; i < 6; i++) begin
            ack_v = (i != 3);
            s_if.ack = ack_v;
            tick();
            checks++;
            if (gnt !== 2'b01 || s_if.adr !== 32'h0000_0C80 || s_if.we !== 1'b1
                || m0_if.ack !== ack_v || m1_if.ack !== 1'b0) begin
                errors++;
                $display("FAIL single_master: gnt=%b adr=%h we=%b ack0=%b ack1=%b expected 01/00000c80/1/%b/0",
                         gnt, s_if.adr, s_if.we, m0_if.ack, m1_if.ack, ack_v);
            end
        end
        m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
        tick();
        checks++;
        if (gnt !== 2'b00 || m0_if.ack !== 1'b0) begin
            errors++;
            $display("FAIL single_release: gnt=%b ack0=%b expected 00/0", gnt, m0_if.ack);
        end
    endtask

    task automatic test_tie();
        logic [1:0] exp;
        do_reset();
        s_if.ack = 1'b1;
        foreach (tie_tbl[i]) begin
            m0_if.cyc = tie_tbl[i].c0; m0_if.stb = tie_tbl[i].c0;
            m1_if.cyc = tie_tbl[i].c1; m1_if.stb = tie_tbl[i].c1;
            m0_if.adr = 32'h100 + 32'(i); m1_if.adr = 32'h200 + 32'(i);
            tick();
            exp = FIXED_PRIO ? tie_tbl[i].fp : tie_tbl[i].rr;
            checks++;
            if (gnt !== exp) begin
                errors++;
                $display("FAIL tie_step%0d: gnt got %b expected %b", i, gnt, exp);
            end
        end
    endtask

    task automatic test_pattern_writer();
        int  win_acks = 0;
        int  grant_acks = 0;
        bit  drop_m1 = 1'b0;
        obs_t o, e;
        do_reset();
        s_if.ack = 1'b1;
        m0_if.stb = 1'b1; m0_if.we = 1'b1; m0_if.sel = 4'hF;
        m1_if.we = 1'b0; m1_if.sel = 4'hF;
        for (int t = 0; t < 256; t++) begin
            m0_if.cyc = ((t % 64) != 63);
            m1_if.cyc = !drop_m1; m1_if.stb = !drop_m1;
            m0_if.adr = $urandom; m0_if.dat_ms = $urandom;
            m1_if.adr = $urandom;
            s_if.dat_sm = $urandom;
            if ((t % 64) == 63) begin
                if (t > 63) begin
                    checks++;
                    if (win_acks !== 8) begin
                        errors++;
                        $display("FAIL pattern_window_t%0d: m1 acks got %0d expected 8", t, win_acks);
                    end
                end
                win_acks = 0;
            end
            tick();
            o = observed();
            e = expected();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pattern_t%0d: got %h expected %h", t, o, e);
            end
            if (m1_if.ack === 1'b1) begin
                win_acks++;
                grant_acks++;
            end
            drop_m1 = (grant_acks == 8);
            if (drop_m1) grant_acks = 0;
        end
    endtask

    task automatic test_read_data();
        do_reset();
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h0000_4000;
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL read_grant: gnt got %b expected 10", gnt);
        end
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
        s_if.dat_sm = 32'h00FF_FFFF; s_if.ack = 1'b1;
        #1;
        checks++;
        if (m1_if.dat_sm !== 32'h00FF_FFFF || m1_if.ack !== 1'b1
            || m0_if.dat_sm !== 32'h0 || m0_if.ack !== 1'b0) begin
            errors++;
            $display("FAIL read_data_same_cycle: dat1=%h ack1=%b dat0=%h ack0=%b expected 00ffffff/1/0/0",
                     m1_if.dat_sm, m1_if.ack, m0_if.dat_sm, m0_if.ack);
        end
        tick();
        checks++;
        if (gnt !== 2'b10 || m1_if.dat_sm !== 32'h00FF_FFFF || m0_if.ack !== 1'b0) begin
            errors++;
            $display("FAIL read_data_held: gnt=%b dat1=%h ack0=%b expected 10/00ffffff/0",
                     gnt, m1_if.dat_sm, m0_if.ack);
        end
    endtask

    task automatic test_idle_masking();
        do_reset();
        m0_if.stb = 1'b1; m0_if.cyc = 1'b0;
        s_if.ack = 1'b1; s_if.dat_sm = 32'h1357_9BDF;
        tick();
        checks++;
        if (gnt !== 2'b00 || s_if.stb !== 1'b0 || m0_if.ack !== 1'b0 || m0_if.dat_sm !== 32'h0) begin
            errors++;
            $display("FAIL idle_masking: gnt=%b s_stb=%b ack0=%b dat0=%h expected 00/0/0/0",
                     gnt, s_if.stb, m0_if.ack, m0_if.dat_sm);
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        do_reset();
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h0000_0C80;
        tick();
        s_if.ack = 1'b1; s_if.dat_sm = 32'hCAFE_F00D;
        #3;
        rst_n = 1'b0;
        #1;
        o = observed();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL async_reset_midcycle: got %h expected 0", o);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        owner = -1;
        last_srv = 1;
        tick();
        checks++;
        if (gnt !== 2'b00 || s_if.cyc !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_release: gnt=%b s_cyc=%b expected 00/0", gnt, s_if.cyc);
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(3) == 0) m0_if.cyc = ~m0_if.cyc;
            if ($urandom_range(3) == 0) m1_if.cyc = ~m1_if.cyc;
            m0_if.stb = 1'($urandom_range(1)); m0_if.we = 1'($urandom_range(1));
            m0_if.adr = $urandom; m0_if.dat_ms = $urandom; m0_if.sel = 4'($urandom_range(15));
            m1_if.stb = 1'($urandom_range(1)); m1_if.we = 1'($urandom_range(1));
            m1_if.adr = $urandom; m1_if.dat_ms = $urandom; m1_if.sel = 4'($urandom_range(15));
            s_if.ack = 1'($urandom_range(1)); s_if.dat_sm = $urandom;
            tick();
            o = observed();
            e = expected();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random_t%0d: got %h expected %h", t, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_tie();
        test_pattern_writer();
        test_read_data();
        test_idle_masking();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
